mult_seq_ctrl: RTL and testbench

- Sequential shift-and-add controller for the board's unsigned 4x4 multiplier.
- Takes operands from switches with a start/busy/done handshake.
- Runs one partial-product add per clock instead of a full combinational array.
- Drives a registered 8-bit product to the LEDR/HEX display logic; an FSM plus an iteration counter sequences the accumulator.

---
 rtl/mult_pkg.sv | 13 +
 rtl/mult_seq_dp.sv | 44 ++++
 rtl/mult_seq_ctrl.sv | 83 ++++++++
 tb/tb_mult_seq_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mult_pkg;

    localparam int MULT_WIDTH  = 4;
    localparam int MULT_PROD_W = 2 * MULT_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mult_state_t;

endpackage

// File: rtl/mult_seq_dp.sv
// Datapath for the shift-and-add multiplier: operand/accumulator registers, adder and shifters.
module mult_seq_dp
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 advance,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;

    // Accumulator value after this cycle's partial product; also feeds the product register.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (load) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
        end else if (advance) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential 4x4 multiplier controller: FSM, iteration counter and product register.
// Define MULT_SEQ_STEP_EN to gate each RUN iteration on the step pulse.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = 3
) (
    input  logic                 CLOCK_50,
    input  logic                 KEY0,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 step,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [CNT_W-1:0]     iter
);

    mult_state_t        state;
    mult_state_t        state_next;
    logic               adv_en;
    logic               accept;
    logic               advance;
    logic               last;
    logic [2*WIDTH-1:0] acc_next;

`ifdef MULT_SEQ_STEP_EN
    assign adv_en = step;
`else
    logic unused_step;
    assign unused_step = step;
    assign adv_en      = 1'b1;
`endif

    assign accept  = start && ((state == IDLE) || (state == DONE));
    assign advance = (state == RUN) && adv_en;
    assign last    = advance && (iter == CNT_W'(WIDTH - 1));
    assign busy    = (state == RUN);
    assign done    = (state == DONE);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) begin
            state   <= IDLE;
            iter    <= '0;
            product <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                iter <= '0;
            end else if (advance) begin
                iter <= iter + 1'b1;
            end
            if (last) begin
                product <= acc_next;
            end
        end
    end

    mult_seq_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk      (CLOCK_50),
        .rst_n    (KEY0),
        .load     (accept),
        .advance  (advance),
        .a        (a),
        .b        (b),
        .acc_next (acc_next)
    );

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl with a product scoreboard.
module tb_mult_seq_ctrl;

    logic       clk;
    logic       key0;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       step;
    logic       busy;
    logic       done;
    logic [7:0] product;
    logic [2:0] iter;

    int checks;
    int failures;
    logic [7:0] exp_q[$];

    mult_seq_ctrl #(
        .WIDTH (4),
        .CNT_W (3)
    ) dut (
        .CLOCK_50 (clk),
        .KEY0     (key0),
        .start    (start),
        .a        (a),
        .b        (b),
        .step     (step),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .iter     (iter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until done rises or the budget expires; returns edges taken (0 if expired).
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        key0  = 1'b0;
        start = 1'b1;
        a     = 4'hF;
        b     = 4'hF;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00 || iter !== 3'd0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b product=%h iter=%0d, required 0 0 00 0",
                     busy, done, product, iter);
        end
        start = 1'b0;
        key0  = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_full_scale();
        logic [7:0] exp;
        start = 1'b1;
        a     = 4'd15;
        b     = 4'd15;
        tick();
        start = 1'b0;
        exp_q.push_back(8'd225);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || iter !== 3'(i)) begin
                failures++;
                $display("FAIL run_cycle%0d: busy=%b done=%b iter=%0d, required 1 0 %0d",
                         i, busy, done, iter, i);
            end
            if (i < 3) tick();
        end
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || product !== exp) begin
            failures++;
            $display("FAIL done_15x15: done=%b busy=%b product=%h, required 1 0 %h",
                     done, busy, product, exp);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || product !== exp) begin
            failures++;
            $display("FAIL hold_15x15: done=%b busy=%b product=%h, required 0 0 %h",
                     done, busy, product, exp);
        end
    endtask

    task automatic test_products();
        logic [3:0] ta[3] = '{4'd13, 4'd0, 4'd9};
        logic [3:0] tb[3] = '{4'd11, 4'd9, 4'd0};
        int cyc;
        logic [7:0] exp;
        for (int k = 0; k < 3; k++) begin
            start = 1'b1;
            a     = ta[k];
            b     = tb[k];
            tick();
            start = 1'b0;
            a     = 4'd0;
            b     = 4'd0;
            exp_q.push_back(8'(ta[k]) * 8'(tb[k]));
            wait_done(cyc);
            exp = exp_q.pop_front();
            checks++;
            if (cyc !== 4 || product !== exp) begin
                failures++;
                $display("FAIL product_%0dx%0d: latency=%0d product=%h, required 4 %h",
                         ta[k], tb[k], cyc, product, exp);
            end
            tick();
        end
    endtask

    task automatic test_start_held();
        int cyc;
        logic [7:0] exp;
        start = 1'b1;
        a     = 4'd2;
        b     = 4'd3;
        tick();
        exp_q.push_back(8'd6);
        a = 4'd15;
        b = 4'd15;
        tick();
        tick();
        start = 1'b0;
        wait_done(cyc);
        exp = exp_q.pop_front();
        checks++;
        if (cyc !== 2 || product !== exp) begin
            failures++;
            $display("FAIL start_held: edges_left=%0d product=%h, required 2 %h",
                     cyc, product, exp);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [7:0] exp;
        start = 1'b1;
        a     = 4'd4;
        b     = 4'd4;
        tick();
        start = 1'b0;
        exp_q.push_back(8'd16);
        wait_done(cyc);
        exp = exp_q.pop_front();
        checks++;
        if (cyc !== 4 || product !== exp) begin
            failures++;
            $display("FAIL b2b_first: latency=%0d product=%h, required 4 %h", cyc, product, exp);
        end
        start = 1'b1;
        a     = 4'd3;
        b     = 4'd5;
        tick();
        start = 1'b0;
        exp_q.push_back(8'h0F);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || iter !== 3'd0) begin
            failures++;
            $display("FAIL b2b_accept: busy=%b done=%b iter=%0d, required 1 0 0", busy, done, iter);
        end
        wait_done(cyc);
        exp = exp_q.pop_front();
        checks++;
        if (cyc !== 4 || product !== exp) begin
            failures++;
            $display("FAIL b2b_second: latency=%0d product=%h, required 4 %h", cyc, product, exp);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int cyc;
        int seen_done;
        logic [7:0] exp;
        start = 1'b1;
        a     = 4'd7;
        b     = 4'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        key0 = 1'b0;
        tick();
        key0 = 1'b1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00 || iter !== 3'd0) begin
            failures++;
            $display("FAIL abort: busy=%b done=%b product=%h iter=%0d, required 0 0 00 0",
                     busy, done, product, iter);
        end
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || busy) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            failures++;
            $display("FAIL abort_quiet: active_cycles=%0d, required 0", seen_done);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_q.push_back(8'h31);
        wait_done(cyc);
        exp = exp_q.pop_front();
        checks++;
        if (cyc !== 4 || product !== exp) begin
            failures++;
            $display("FAIL restart_7x7: latency=%0d product=%h, required 4 %h", cyc, product, exp);
        end
        tick();
    endtask

`ifdef MULT_SEQ_STEP_EN
    task automatic test_step();
        logic [7:0] exp;
        start = 1'b1;
        a     = 4'd6;
        b     = 4'd9;
        tick();
        start = 1'b0;
        exp_q.push_back(8'h36);
        for (int p = 0; p < 4; p++) begin
            tick();
            tick();
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || iter !== 3'(p)) begin
                failures++;
                $display("FAIL step_hold%0d: busy=%b done=%b iter=%0d, required 1 0 %0d",
                         p, busy, done, iter, p);
            end
            step = 1'b1;
            tick();
            step = 1'b0;
        end
        exp = exp_q.pop_front();
        checks++;
        if (done !== 1'b1 || product !== exp) begin
            failures++;
            $display("FAIL step_done: done=%b product=%h, required 1 %h", done, product, exp);
        end
        tick();
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        key0     = 1'b0;
        start    = 1'b0;
        a        = 4'd0;
        b        = 4'd0;
        step     = 1'b0;
        tick();
        test_reset();
        test_full_scale();
        test_products();
        test_start_held();
        test_back_to_back();
        test_reset_abort();
`ifdef MULT_SEQ_STEP_EN
        test_step();
`endif
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending=%0d, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
